// File: rtl/gf_mixcol_if.sv
// Handshake bundle between the round pipeline and the MixColumns engine.
// The master side feeds states in and drains results; the slave side is the engine.
interface gf_mixcol_if #(
    parameter int NUM_COLS = 4
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    inverse;
    logic [32*NUM_COLS-1:0]  state_in;
    logic                    out_valid;
    logic                    out_ready;
    logic [32*NUM_COLS-1:0]  state_out;
    logic                    busy;

    modport master (
        output in_valid, inverse, state_in, out_ready,
        input  in_ready, out_valid, state_out, busy
    );

    modport slave (
        input  in_valid, inverse, state_in, out_ready,
        output in_ready, out_valid, state_out, busy
    );
endinterface

// File: rtl/gf_mixcol_engine.sv
// Iterative AES MixColumns / InvMixColumns engine.
// A whole state is latched on accept, then COLS_PER_CYCLE columns are rewritten
// in place per cycle; the finished state is held until downstream takes it.
module gf_mixcol_engine #(
    parameter int NUM_COLS       = 4,
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic      clk,
    input  logic      n_rst,
    gf_mixcol_if.slave bus
);

    localparam int SW  = 32 * NUM_COLS;
    localparam int CIW = $clog2(NUM_COLS + 1);

    generate
        if (COLS_PER_CYCLE < 1) begin : g_bad_cpc
            $error("gf_mixcol_engine: COLS_PER_CYCLE must be at least 1");
        end else if ((NUM_COLS < 1) || ((NUM_COLS % COLS_PER_CYCLE) != 0)) begin : g_bad_cols
            $error("gf_mixcol_engine: NUM_COLS must be >= 1 and a multiple of COLS_PER_CYCLE");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CIW-1:0]    col_q, col_d;
    logic              mode_q, mode_d;
    logic [SW-1:0]     work_q, work_d;
    // Holds in_ready low through reset and until the first edge after release.
    logic              live_q;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Only the coefficients used by the two circulants are supported.
    function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [7:0] k);
        logic [7:0] x2, x4, x8, r;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        case (k)
            8'h01:   r = b;
            8'h02:   r = x2;
            8'h03:   r = x2 ^ b;
            8'h09:   r = x8 ^ b;
            8'h0B:   r = x8 ^ x2 ^ b;
            8'h0D:   r = x8 ^ x4 ^ b;
            8'h0E:   r = x8 ^ x4 ^ x2;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // Row 0 is the MSB byte; out_r = XOR_k M[(k-r) mod 4] * a_k.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
        logic [7:0]  m [4];
        logic [7:0]  a [4];
        logic [7:0]  acc;
        logic [31:0] res;
        if (inv) begin
            m[0] = 8'h0E; m[1] = 8'h0B; m[2] = 8'h0D; m[3] = 8'h09;
        end else begin
            m[0] = 8'h02; m[1] = 8'h03; m[2] = 8'h01; m[3] = 8'h01;
        end
        for (int i = 0; i < 4; i++) begin
            a[i] = col[31-8*i -: 8];
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
                acc = acc ^ gf_mul(a[k], m[(k - r + 4) % 4]);
            end
            res[31-8*r -: 8] = acc;
        end
        return res;
    endfunction

    // State, column pointer, mode and working register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state logic and the in-place column rewrite.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        mode_d  = mode_q;
        work_d  = work_q;
        case (state_q)
            IDLE: begin
                if (live_q && bus.in_valid) begin
                    work_d  = bus.state_in;
                    mode_d  = bus.inverse;
                    col_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                for (int g = 0; g < COLS_PER_CYCLE; g++) begin
                    int c;
                    c = int'(col_q) + g;
                    if (c < NUM_COLS) begin
                        work_d[SW-1-32*c -: 32] = mix_col(work_q[SW-1-32*c -: 32], mode_q);
                    end
                end
                col_d = col_q + CIW'(COLS_PER_CYCLE);
                if (col_q == CIW'(NUM_COLS - COLS_PER_CYCLE)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = live_q && (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q == BUSY) || (state_q == DONE);
    assign bus.state_out = work_q;

endmodule

// File: tb/tb_gf_mixcol_engine.sv
// Directed bench for gf_mixcol_engine: FIPS-197 vectors, latency, backpressure,
// mode stability and mid-transaction reset, plus a 4-columns-per-cycle instance.
module tb_gf_mixcol_engine;

    localparam logic [127:0] VEC_A = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] VEC_B = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;

    logic clk;
    logic n_rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    gf_mixcol_if #(.NUM_COLS(4)) bus_a ();
    gf_mixcol_if #(.NUM_COLS(4)) bus_b ();

    gf_mixcol_engine #(.NUM_COLS(4), .COLS_PER_CYCLE(1)) dut_a (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_a)
    );

    gf_mixcol_engine #(.NUM_COLS(4), .COLS_PER_CYCLE(4)) dut_b (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller sits #1 after a rising edge; returns #1 after the accept edge.
    task automatic start_a(input logic [127:0] din, input logic inv, input string tag);
        check_val({tag, "_in_ready"}, bus_a.in_ready, 1'b1);
        bus_a.state_in = din;
        bus_a.inverse  = inv;
        bus_a.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic wait_done_a(input int exp_lat, input logic [127:0] exp_out, input string tag);
        int lat = 0;
        while (!bus_a.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val({tag, "_latency"}, lat, exp_lat);
        check_val({tag, "_result"}, bus_a.state_out, exp_out);
        check_val({tag, "_busy"}, bus_a.busy, 1'b1);
        check_val({tag, "_in_ready_done"}, bus_a.in_ready, 1'b0);
    endtask

    task automatic release_a(input string tag);
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
        check_val({tag, "_out_valid_drop"}, bus_a.out_valid, 1'b0);
        check_val({tag, "_in_ready_back"}, bus_a.in_ready, 1'b1);
        check_val({tag, "_busy_drop"}, bus_a.busy, 1'b0);
    endtask

    initial begin
        logic [127:0] held;
        int lat;

        n_rst           = 1'b0;
        bus_a.in_valid  = 1'b0;
        bus_a.inverse   = 1'b0;
        bus_a.state_in  = '0;
        bus_a.out_ready = 1'b0;
        bus_b.in_valid  = 1'b0;
        bus_b.inverse   = 1'b0;
        bus_b.state_in  = '0;
        bus_b.out_ready = 1'b0;

        // Reset values
        #12;
        check_val("rst_in_ready", bus_a.in_ready, 1'b0);
        check_val("rst_out_valid", bus_a.out_valid, 1'b0);
        check_val("rst_busy", bus_a.busy, 1'b0);
        check_val("rst_state_out", bus_a.state_out, 128'h0);
        @(posedge clk); #1;
        n_rst = 1'b1;
        #1;
        check_val("rel_in_ready_pre_edge", bus_a.in_ready, 1'b0);
        @(posedge clk); #1;
        check_val("rel_in_ready_post_edge", bus_a.in_ready, 1'b1);

        // Forward FIPS-197 column set
        start_a(VEC_A, 1'b0, "fwd");
        check_val("fwd_out_valid_early", bus_a.out_valid, 1'b0);
        wait_done_a(4, VEC_B, "fwd");
        release_a("fwd");

        // Inverse brings it back
        start_a(VEC_B, 1'b1, "inv");
        wait_done_a(4, VEC_A, "inv");
        release_a("inv");

        // Backpressure: result held, new requests ignored
        start_a(VEC_A, 1'b0, "bp");
        wait_done_a(4, VEC_B, "bp");
        held = bus_a.state_out;
        for (int i = 0; i < 6; i++) begin
            bus_a.in_valid = i[0];
            bus_a.state_in = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210 ^ 128'(i);
            bus_a.inverse  = ~i[0];
            @(posedge clk); #1;
            check_val("bp_state_stable", bus_a.state_out, held);
            check_val("bp_out_valid", bus_a.out_valid, 1'b1);
            check_val("bp_in_ready", bus_a.in_ready, 1'b0);
        end
        bus_a.in_valid = 1'b0;
        release_a("bp");
        @(posedge clk); #1;
        check_val("bp_no_ghost_txn", bus_a.busy, 1'b0);

        // Mode change after accept has no effect
        start_a(VEC_B, 1'b1, "mode");
        @(posedge clk); #1;
        bus_a.inverse = 1'b0;
        wait_done_a(3, VEC_A, "mode");
        release_a("mode");

        // Reset during the second BUSY cycle
        start_a(VEC_A, 1'b0, "midrst");
        @(posedge clk); #1;
        n_rst = 1'b0;
        #1;
        check_val("midrst_state_out", bus_a.state_out, 128'h0);
        check_val("midrst_out_valid", bus_a.out_valid, 1'b0);
        check_val("midrst_in_ready", bus_a.in_ready, 1'b0);
        check_val("midrst_busy", bus_a.busy, 1'b0);
        @(posedge clk); #1;
        check_val("midrst_held_out_valid", bus_a.out_valid, 1'b0);
        n_rst = 1'b1;
        #1;
        check_val("midrst_in_ready_pre_edge", bus_a.in_ready, 1'b0);
        @(posedge clk); #1;
        check_val("midrst_in_ready_post_edge", bus_a.in_ready, 1'b1);
        check_val("midrst_no_result", bus_a.out_valid, 1'b0);
        start_a(VEC_A, 1'b0, "after_rst");
        wait_done_a(4, VEC_B, "after_rst");
        release_a("after_rst");

        // Four columns per cycle instance
        check_val("wide_in_ready", bus_b.in_ready, 1'b1);
        bus_b.state_in = VEC_A;
        bus_b.inverse  = 1'b0;
        bus_b.in_valid = 1'b1;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        check_val("wide_busy", bus_b.busy, 1'b1);
        lat = 0;
        while (!bus_b.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("wide_latency", lat, 1);
        check_val("wide_result", bus_b.state_out, VEC_B);
        bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_b.out_ready = 1'b0;
        check_val("wide_out_valid_drop", bus_b.out_valid, 1'b0);
        check_val("wide_in_ready_back", bus_b.in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
